// File: rtl/avalon_mm_initiator.sv
// avalon_mm_initiator: bridges a valid/ready command/response stream to a single-outstanding Avalon-MM initiator.
// Ports:
//   clk, reset_n                            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                     command handshake (ready only in IDLE)
//   cmd_write, cmd_address, cmd_wdata       command payload (1=write, 0=read)
//   rsp_valid/rsp_ready                     response handshake
//   rsp_rdata, rsp_error                    read data (0 for writes/timeouts), timeout flag
//   avm_chipselect, avm_read, avm_write     registered Avalon-MM strobes
//   avm_address, avm_writedata              registered Avalon-MM address/data
//   avm_readdata, avm_waitrequest           Avalon-MM slave returns
module avalon_mm_initiator #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d, err_q, err_d;
    logic              timeout;

    // Counter holds TIMEOUT-1 on the last allowed wait cycle, so the bus is held exactly TIMEOUT cycles.
    assign timeout = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs_d     = cs_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (cmd_valid && ready_q) begin
                state_d = BUS;
                cnt_d   = '0;
                cs_d    = 1'b1;
                rd_d    = !cmd_write;
                wr_d    = cmd_write;
                addr_d  = cmd_address;
                wdata_d = cmd_wdata;
            end
            // A dropped waitrequest takes priority over a coincident timeout.
            BUS: if (!avm_waitrequest || timeout) begin
                state_d  = RESP;
                cs_d     = 1'b0;
                rd_d     = 1'b0;
                wr_d     = 1'b0;
                rvalid_d = 1'b1;
                err_d    = avm_waitrequest;
                rdata_d  = (!avm_waitrequest && rd_q) ? avm_readdata : '0;
            end else begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
            end
            RESP: if (rsp_ready) begin
                state_d  = IDLE;
                rvalid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Registered so cmd_ready stays low during reset and rises on the first edge after it.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            cs_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            cs_q     <= cs_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready      = ready_q;
    assign rsp_valid      = rvalid_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_error      = err_q;
    assign avm_chipselect = cs_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
endmodule

// File: tb/tb_avalon_mm_initiator.sv
// tb_avalon_mm_initiator: directed self-checking bench for avalon_mm_initiator with TIMEOUT=4.
module tb_avalon_mm_initiator;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [1:0]  cmd_address = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_error;
    logic [31:0] rsp_rdata;
    logic        avm_chipselect, avm_read, avm_write;
    logic [1:0]  avm_address;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    int          vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    avalon_mm_initiator #(.ADDR_W(2), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .avm_chipselect(avm_chipselect), .avm_read(avm_read), .avm_write(avm_write),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle mid-low-phase for sampling and driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_error", 32'(rsp_error), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_strobes", {29'd0, avm_chipselect, avm_read, avm_write}, 0);
        chk("rst_addr", 32'(avm_address), 0);
        chk("rst_wdata", avm_writedata, 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(cmd_ready), 1);
        // Zero-wait write of 0x5 to address 0.
        issue(1'b1, 2'd0, 32'h5);
        chk("wr_strobes", {29'd0, avm_chipselect, avm_read, avm_write}, 32'b101);
        chk("wr_wdata", avm_writedata, 32'h5);
        chk("wr_cmd_ready", 32'(cmd_ready), 0);
        tick();
        chk("wr_done_strobes", {29'd0, avm_chipselect, avm_read, avm_write}, 0);
        chk("wr_rsp_valid", 32'(rsp_valid), 1);
        chk("wr_rsp_error", 32'(rsp_error), 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        tick();
        chk("wr_idle_ready", 32'(cmd_ready), 1);
        chk("wr_idle_valid", 32'(rsp_valid), 0);
        // Read with 3 wait states; readdata is garbage until the completing edge.
        avm_waitrequest = 1'b1; avm_readdata = 32'hDEADBEEF;
        issue(1'b0, 2'd2, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("rd3_read", {30'd0, avm_chipselect, avm_read}, 32'b11);
            chk("rd3_addr", 32'(avm_address), 2);
            chk("rd3_no_rsp", 32'(rsp_valid), 0);
            if (i == 3) begin avm_waitrequest = 1'b0; avm_readdata = 32'h5; end
            tick();
        end
        avm_readdata = 32'hDEADBEEF;
        chk("rd3_read_off", 32'(avm_read), 0);
        chk("rd3_rsp_valid", 32'(rsp_valid), 1);
        chk("rd3_rdata", rsp_rdata, 32'h5);
        chk("rd3_error", 32'(rsp_error), 0);
        tick();
        // Timeout: waitrequest stuck high, bus held exactly 4 cycles.
        avm_waitrequest = 1'b1; avm_readdata = 32'hFFFFFFFF;
        issue(1'b0, 2'd1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_read", 32'(avm_read), 1);
            tick();
        end
        chk("to_read_off", {29'd0, avm_chipselect, avm_read, avm_write}, 0);
        chk("to_rsp_valid", 32'(rsp_valid), 1);
        chk("to_error", 32'(rsp_error), 1);
        chk("to_rdata", rsp_rdata, 0);
        tick();
        chk("to_idle_ready", 32'(cmd_ready), 1);
        // Next command proceeds normally, then its response is back-pressured for 5 cycles.
        avm_waitrequest = 1'b0; avm_readdata = 32'h12345678; rsp_ready = 1'b0;
        issue(1'b0, 2'd3, 32'h0);
        chk("nx_read", 32'(avm_read), 1);
        tick();
        avm_readdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rdata", rsp_rdata, 32'h12345678);
            chk("bp_error", 32'(rsp_error), 0);
            chk("bp_cmd_ready", 32'(cmd_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_ready", 32'(cmd_ready), 1);
        chk("bp_release_valid", 32'(rsp_valid), 0);
        // Write where waitrequest falls on the 4th bus cycle: completion beats the timeout.
        avm_waitrequest = 1'b1;
        issue(1'b1, 2'd2, 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            chk("cvt_write", 32'(avm_write), 1);
            chk("cvt_wdata", avm_writedata, 32'h11223344);
            if (i == 3) avm_waitrequest = 1'b0;
            tick();
        end
        chk("cvt_rsp_valid", 32'(rsp_valid), 1);
        chk("cvt_error", 32'(rsp_error), 0);
        chk("cvt_rdata", rsp_rdata, 0);
        tick();
        // Reset during wait state 2 drops strobes immediately and yields no response.
        avm_waitrequest = 1'b1;
        issue(1'b0, 2'd1, 32'h0);
        tick();
        chk("mr_read_before", 32'(avm_read), 1);
        reset_n = 1'b0;
        #1;
        chk("mr_strobes", {29'd0, avm_chipselect, avm_read, avm_write}, 0);
        chk("mr_rsp_valid", 32'(rsp_valid), 0);
        chk("mr_cmd_ready", 32'(cmd_ready), 0);
        tick();
        avm_waitrequest = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("mr_post_valid", 32'(rsp_valid), 0);
        chk("mr_post_ready", 32'(cmd_ready), 1);
        avm_readdata = 32'h87654321;
        issue(1'b0, 2'd3, 32'h0);
        chk("mr_rd_addr", 32'(avm_address), 3);
        tick();
        chk("mr_rd_valid", 32'(rsp_valid), 1);
        chk("mr_rd_rdata", rsp_rdata, 32'h87654321);
        chk("mr_rd_error", 32'(rsp_error), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
